// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the elastic pipeline-stage register:
// default payload widths, the "no destination register" code and FSM encodings.
package pipe_stage_reg_pkg;

    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_ADDR_W  = 4;
    localparam int unsigned DEF_PC_W    = 16;
    localparam int unsigned STALL_CNT_W = 16;

    // Destination code meaning "no register"; writeback logic ignores it.
    localparam logic [DEF_ADDR_W-1:0] REG_INVALID = 4'hf;

    localparam logic [1:0] PSR_EMPTY = 2'd0;
    localparam logic [1:0] PSR_ONE   = 2'd1;
    localparam logic [1:0] PSR_TWO   = 2'd2;

endpackage

// File: rtl/pipe_payload_reg.sv
// One payload-wide register with load and bubble-load (clear to bubble value).
// Bubble-load wins over load; reset also returns the bubble value.
module pipe_payload_reg #(
    parameter int unsigned   W      = 1,
    parameter logic [W-1:0]  BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         bubble_load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Payload storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BUBBLE;
        end else if (bubble_load) begin
            q <= BUBBLE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register (main + skid entry) with valid/ready handshake,
// fully registered upstream ready and synchronous flush.
// Optional stall-cycle counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned        DATA_W       = DEF_DATA_W,
    parameter int unsigned        ADDR_W       = DEF_ADDR_W,
    parameter int unsigned        PC_W         = DEF_PC_W,
    parameter logic [15:0]        RESET_RESULT = 16'h00dd,
    parameter logic [ADDR_W-1:0]  REG_NONE     = ADDR_W'(REG_INVALID)
) (
    input  logic              psi_clk,
    input  logic              psi_rst,
    input  logic              psi_valid,
    output logic              pso_ready,
    input  logic [PC_W-1:0]   psi_instr,
    input  logic [PC_W-1:0]   psi_pc,
    input  logic [DATA_W-1:0] psi_result,
    input  logic [ADDR_W-1:0] psi_wreg_addr,
    input  logic              psi_reg_wrn,
    input  logic              psi_flush,
    output logic              pso_valid,
    input  logic              psi_ready,
    output logic [PC_W-1:0]   pso_instr,
    output logic [PC_W-1:0]   pso_pc,
    output logic [DATA_W-1:0] pso_result,
    output logic [ADDR_W-1:0] pso_wreg_addr,
    output logic              pso_reg_wrn
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] pso_stall_cnt
`endif
);

    localparam int unsigned PW = 2 * PC_W + DATA_W + ADDR_W + 1;
    localparam logic [PW-1:0] BUBBLE = {{(2 * PC_W){1'b0}}, DATA_W'(RESET_RESULT), REG_NONE, 1'b0};

    logic [1:0]    state_q, state_d;
    logic          ready_q, valid_q;
    logic          accept, pop;
    logic          main_load, main_from_skid, main_bubble;
    logic          skid_load, skid_bubble;
    logic [PW-1:0] in_payload, main_d, main_q, skid_q;

    assign accept     = psi_valid & ready_q;
    assign pop        = valid_q & psi_ready;
    assign in_payload = {psi_instr, psi_pc, psi_result, psi_wreg_addr, psi_reg_wrn};
    assign main_d     = main_from_skid ? skid_q : in_payload;

    // Next-state and entry-load decode; flush overrides every transfer.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_bubble    = 1'b0;
        skid_load      = 1'b0;
        skid_bubble    = 1'b0;
        if (psi_flush) begin
            state_d     = PSR_EMPTY;
            main_bubble = 1'b1;
            skid_bubble = 1'b1;
        end else begin
            case (state_q)
                PSR_EMPTY: begin
                    if (accept) begin
                        state_d   = PSR_ONE;
                        main_load = 1'b1;
                    end
                end
                PSR_ONE: begin
                    case ({accept, pop})
                        2'b11: main_load = 1'b1;
                        2'b10: begin
                            state_d   = PSR_TWO;
                            skid_load = 1'b1;
                        end
                        2'b01: begin
                            state_d     = PSR_EMPTY;
                            main_bubble = 1'b1;
                        end
                        default: ;
                    endcase
                end
                PSR_TWO: begin
                    if (pop) begin
                        state_d        = PSR_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_bubble    = 1'b1;
                    end
                end
                default: begin
                    state_d     = PSR_EMPTY;
                    main_bubble = 1'b1;
                    skid_bubble = 1'b1;
                end
            endcase
        end
    end

    // State register plus registered handshake flags derived from the next state.
    always_ff @(posedge psi_clk or negedge psi_rst) begin
        if (!psi_rst) begin
            state_q <= PSR_EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != PSR_TWO);
            valid_q <= (state_d != PSR_EMPTY);
        end
    end

    pipe_payload_reg #(.W(PW), .BUBBLE(BUBBLE)) u_main (
        .clk         (psi_clk),
        .rst_n       (psi_rst),
        .load        (main_load),
        .bubble_load (main_bubble),
        .d           (main_d),
        .q           (main_q)
    );

    pipe_payload_reg #(.W(PW), .BUBBLE(BUBBLE)) u_skid (
        .clk         (psi_clk),
        .rst_n       (psi_rst),
        .load        (skid_load),
        .bubble_load (skid_bubble),
        .d           (in_payload),
        .q           (skid_q)
    );

    assign pso_ready = ready_q;
    assign pso_valid = valid_q;
    assign {pso_instr, pso_pc, pso_result, pso_wreg_addr, pso_reg_wrn} = main_q;

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    // Saturating count of cycles where output is valid but not taken; flush keeps it.
    always_ff @(posedge psi_clk or negedge psi_rst) begin
        if (!psi_rst) begin
            stall_cnt_q <= '0;
        end else if (valid_q && !psi_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign pso_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random traffic
// compared against a queue-based FIFO model (capacity 2, registered ready).
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, out_ready_in = 1'b0, flush = 1'b0;
    logic [15:0] in_instr = '0, in_pc = '0, in_result = '0;
    logic [3:0]  in_wa = '0;
    logic        in_wrn = 1'b0;
    logic        o_ready, o_valid, o_wrn;
    logic [15:0] o_instr, o_pc, o_result;
    logic [3:0]  o_wa;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [15:0] o_stall;
`endif

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] result;
        logic [3:0]  wa;
        logic        wrn;
    } pl_t;

    pl_t q[$];
    int  stall_m = 0;
    int  errors = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .psi_clk       (clk),
        .psi_rst       (rst),
        .psi_valid     (in_valid),
        .pso_ready     (o_ready),
        .psi_instr     (in_instr),
        .psi_pc        (in_pc),
        .psi_result    (in_result),
        .psi_wreg_addr (in_wa),
        .psi_reg_wrn   (in_wrn),
        .psi_flush     (flush),
        .pso_valid     (o_valid),
        .psi_ready     (out_ready_in),
        .pso_instr     (o_instr),
        .pso_pc        (o_pc),
        .pso_result    (o_result),
        .pso_wreg_addr (o_wa),
        .pso_reg_wrn   (o_wrn)
`ifdef PIPE_STAGE_STALL_CNT_EN
        ,
        .pso_stall_cnt (o_stall)
`endif
    );

    // Held payload must not change while the consumer stalls it.
    property p_hold;
        @(posedge clk) disable iff (!rst)
        (o_valid && !out_ready_in && !flush) |=>
            ($stable(o_pc) && $stable(o_instr) && $stable(o_result) && $stable(o_wa) && $stable(o_wrn));
    endproperty
    a_hold: assert property (p_hold) else $error("FAIL hold: payload changed while stalled");

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare every output against the model's view of the queue.
    task automatic compare_all();
        logic        ev;
        pl_t         e;
        ev = (q.size() > 0);
        if (ev) e = q[0];
        else begin
            e.instr = 16'h0; e.pc = 16'h0; e.result = 16'h00dd; e.wa = REG_INVALID; e.wrn = 1'b0;
        end
        check("valid",  32'(o_valid),  32'(ev));
        check("ready",  32'(o_ready),  32'(q.size() < 2));
        check("instr",  32'(o_instr),  32'(e.instr));
        check("pc",     32'(o_pc),     32'(e.pc));
        check("result", 32'(o_result), 32'(e.result));
        check("wa",     32'(o_wa),     32'(e.wa));
        check("wrn",    32'(o_wrn),    32'(e.wrn));
`ifdef PIPE_STAGE_STALL_CNT_EN
        check("stall_cnt", 32'(o_stall), 32'(stall_m));
`endif
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then check.
    task automatic cycle(input logic v, input logic r, input logic f, input logic [15:0] pc);
        pl_t p;
        bit  acc, pop;
        p.instr  = 16'($urandom);
        p.pc     = pc;
        p.result = 16'($urandom);
        p.wa     = 4'($urandom);
        p.wrn    = 1'($urandom);
        in_valid = v; out_ready_in = r; flush = f;
        in_instr = p.instr; in_pc = p.pc; in_result = p.result; in_wa = p.wa; in_wrn = p.wrn;
        acc = v && (q.size() < 2);
        pop = (q.size() > 0) && r;
        if ((q.size() > 0) && !r && (stall_m < 65535)) stall_m++;
        @(posedge clk);
        if (f) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(p);
        end
        #1;
        compare_all();
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 16'h0);

        // Streaming: one transfer per cycle, 1-cycle latency.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b1, 1'b0, 16'(i));
        cycle(1'b0, 1'b1, 1'b0, 16'h0);

        // Back-pressure: third push held upstream, released in order.
        cycle(1'b1, 1'b0, 1'b0, 16'h10);
        cycle(1'b1, 1'b0, 1'b0, 16'h11);
        cycle(1'b1, 1'b0, 1'b0, 16'h12);
        cycle(1'b1, 1'b1, 1'b0, 16'h12);
        cycle(1'b1, 1'b1, 1'b0, 16'h12);
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 16'h0);

        // Flush in TWO with simultaneous valid, then flush discarding a same-cycle accept.
        cycle(1'b1, 1'b0, 1'b0, 16'h30);
        cycle(1'b1, 1'b0, 1'b0, 16'h31);
        cycle(1'b1, 1'b0, 1'b1, 16'h20);
        cycle(1'b1, 1'b0, 1'b0, 16'h40);
        cycle(1'b1, 1'b1, 1'b1, 16'h21);
        cycle(1'b0, 1'b1, 1'b0, 16'h0);

        // Stall counting for 5 cycles, then flush leaves the count.
        cycle(1'b1, 1'b0, 1'b0, 16'h50);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 1'b1, 16'h0);
        cycle(1'b0, 1'b1, 1'b0, 16'h0);

        // Asynchronous reset mid-cycle while holding one entry.
        cycle(1'b1, 1'b1, 1'b0, 16'h60);
        in_valid = 1'b0;
        #3;
        rst = 1'b0;
        q.delete();
        stall_m = 0;
        #1;
        compare_all();
        #1;
        rst = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 16'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 32) == 0, 16'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
